// File: rtl/fa_exerciser.sv
// Stimulus/response engine for a 1-bit full adder: walks all 8 input vectors and checks sum/c_out.
// Optional STOP_ON_ERROR_EN ends the sweep at the first mismatching vector.
module fa_exerciser #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c_in,
    input  logic       sum,
    input  logic       c_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] vec_idx
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StDrive = 2'd1;
    localparam logic [1:0] StCheck = 2'd2;
    localparam logic [1:0] StFin   = 2'd3;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(SETTLE_CYCLES - 1);

`ifdef STOP_ON_ERROR_EN
    localparam logic StopOnErr = 1'b1;
`else
    localparam logic StopOnErr = 1'b0;
`endif

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       vec_q, vec_d;
    logic [3:0]       err_q, err_d;
    logic             pass_q, pass_d;

    logic [2:0] cur_vec;
    logic       exp_sum, exp_cout, mismatch;

    // Sweep order: by number of ones, then a-first.
    function automatic logic [2:0] vec_bits(input logic [2:0] idx);
        logic [2:0] bits;
        case (idx)
            3'd0:    bits = 3'b000;
            3'd1:    bits = 3'b100;
            3'd2:    bits = 3'b010;
            3'd3:    bits = 3'b001;
            3'd4:    bits = 3'b110;
            3'd5:    bits = 3'b101;
            3'd6:    bits = 3'b011;
            default: bits = 3'b111;
        endcase
        return bits;
    endfunction

    assign cur_vec  = vec_bits(vec_q);
    assign exp_sum  = ^cur_vec;
    assign exp_cout = (cur_vec[2] & cur_vec[1]) | (cur_vec[2] & cur_vec[0]) |
                      (cur_vec[1] & cur_vec[0]);
    assign mismatch = (sum != exp_sum) || (c_out != exp_cout);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        err_d   = err_q;
        pass_d  = pass_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    err_d   = 4'd0;
                    pass_d  = 1'b0;
                    vec_d   = 3'd0;
                    cnt_d   = '0;
                    state_d = StDrive;
                end
            end
            StDrive: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CntLast) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (mismatch) begin
                    err_d = err_q + 4'd1;
                end
                // On an early stop vec_idx keeps the failing index for inspection.
                if (StopOnErr && mismatch) begin
                    state_d = StFin;
                end else if (vec_q == 3'd7) begin
                    vec_d   = 3'd0;
                    state_d = StFin;
                end else begin
                    vec_d   = vec_q + 3'd1;
                    cnt_d   = '0;
                    state_d = StDrive;
                end
            end
            default: begin
                pass_d  = (err_q == 4'd0);
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            vec_q   <= 3'd0;
            err_q   <= 4'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
        end
    end

    assign busy            = (state_q == StDrive) || (state_q == StCheck);
    assign done            = (state_q == StFin);
    assign {a, b, c_in}    = busy ? cur_vec : 3'b000;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign vec_idx         = vec_q;

endmodule
